sqdiff_acc: RTL and testbench
=============================

Name: sqdiff_acc

Overview:
Parametrised, pipelined squared-difference unit with a valid qualifier and an optional accumulate mode.
- Per sample it computes (a-b)^2 - c on unsigned W-bit operands.
- In mode 0 it emits each per-sample result.
- In mode 1 it sums LEN consecutive valid per-sample results and emits one total.
- Sits in the datapath lab blocks as the successor of the fixed 6-bit registered squared-difference unit, feeding error/energy metrics downstream.

Parameters:
W, 6, unsigned input operand width (W >= 2)
LEN, 4, number of valid samples summed per output in mode 1 (LEN >= 2)
(derived, not overridable) RW = 2*W+1, per-sample signed result width
(derived) CW = $clog2(LEN+1), sample-counter width
(derived) AW = RW + $clog2(LEN), accumulator/output width

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
clr  input  1  synchronous flush: kills pipeline valids, zeroes accumulator and counter
mode  input  1  0 = per-sample output, 1 = accumulate LEN samples
in_valid  input  1  a/b/c valid this cycle
a  input  W  unsigned operand
b  input  W  unsigned operand
c  input  W  unsigned offset
out_valid  output  1  result valid, single-cycle pulse per result
result  output  AW  signed result, two's complement
count  output  CW  valid samples currently held in accumulator (mode 1), 0 in mode 0

Behaviour:
- Reset (rst=0 at edge): all pipeline data and valid registers, accumulator, count, out_valid and result go to 0. rst has priority over clr and in_valid. Reset mid-accumulation discards the partial sum.
- Pipeline: four register stages, each carrying a valid bit; no backpressure, no stall.
  - E1: capture a, b, c, in_valid.
  - E2: x = signed(W+1) ad - bd; c delayed.
  - E3: y = x*x, unsigned 2W bits (max (2^W-1)^2 always fits); c delayed.
  - E4: p = signed RW-bit y - c.
- Latency: a sample presented with in_valid=1 before edge N produces p at edge N+3. Fully pipelined, one sample per cycle. in_valid gaps propagate as bubbles.
- Mode 0: at edge N+3, out_valid=1 and result = p sign-extended to AW. out_valid=0 on bubble cycles; result holds its last value.
- Mode 1:
  - acc/count update only on valid E3->E4 transfers.
  - For the LEN-th valid sample: result = acc + p, out_valid=1 for one cycle, acc <- 0, count <- 0.
  - Otherwise: acc <- acc + p, count <- count+1, out_valid=0.
  - The next group starts with the next valid sample, with no lost cycle.
  - AW guarantees no overflow: |sum| <= LEN*(2^W-1)^2.
- mode is quasi-static. It must change only together with a clr pulse (or during reset). The block samples it combinationally at the E4 stage. Behaviour for a mode change without clr is undefined and is not verified.
- clr=1 at an edge: all stage valids, acc, count and out_valid <- 0. Data registers may hold stale values. A sample presented in the same cycle as clr is dropped (clr wins). Samples presented the cycle after clr are processed normally.
- Signedness: a, b, c are unsigned. x, p and result are signed. c is zero-extended before subtraction.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with random inputs and in_valid=1 -> out_valid=0, result=0, count=0. Release; no out_valid until 4 edges after the first valid sample.
- Mode 0 stream (W=6), back-to-back (a,b,c): (4,8,2),(5,8,2),(2,7,3),(0,2,16),(9,9,10),(63,63,62),(16,2,16),(10,9,1) -> result sequence 14, 7, 22, -12, -10, -62, 180, 0, each with out_valid, first result 3 edges after first sample is registered.
- Mode 0 extremes: (63,0,0) -> 3969; (0,63,63) -> 3906; (0,0,63) -> -63 (sign-extended, result=15'h7FC1 for AW=15).
- Mode 1, LEN=4, the 8-sample stream above with a 2-cycle in_valid gap after sample 2 -> exactly two out_valid pulses: 31 then 108. count steps 1,2,3,0 per group and does not advance during the gap.
- Mode 1 max: LEN=4, four samples (63,0,0) -> result 15876, no overflow.
- Flush/reset mid-group:
  - clr after 2 samples of a group, then samples 14,7,22,-12 -> single pulse 31 (partial sum discarded).
  - Repeat with rst=0 instead of clr -> same result.
  - clr asserted in the same cycle as in_valid -> that sample never appears.

Source files
------------

// File: rtl/sqdiff_acc.sv
// rtl/sqdiff_acc.sv - pipelined (a-b)^2 - c with optional LEN-sample accumulation
// Four registered stages with valid bits; E4 either emits each sample or sums LEN of them.
module sqdiff_acc #(
  parameter int W   = 6,
  parameter int LEN = 4,
  localparam int RW = 2*W+1,
  localparam int CW = $clog2(LEN+1),
  localparam int AW = RW + $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  output logic          out_valid,
  output logic [AW-1:0] result,
  output logic [CW-1:0] count
);

  logic [W-1:0]        r_a1, r_b1, r_c1, r_c2, r_c3;
  logic                r_v1, r_v2, r_v3;
  logic signed [W:0]   r_x2;
  logic [2*W-1:0]      r_y3;
  logic [AW-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_out_valid;
  logic [AW-1:0]       r_result;

  logic signed [W:0]     w_x;
  logic signed [2*W-1:0] w_xe;
  logic [2*W-1:0]        w_y;
  logic signed [RW-1:0]  w_p;
  logic [AW-1:0]         w_p_ext;
  logic [AW-1:0]         w_sum;
  logic                  w_last;

  assign w_x  = $signed({1'b0, r_a1}) - $signed({1'b0, r_b1});
  // Squaring at 2W bits: the true square always fits, so the truncated product is exact.
  assign w_xe = {{(W-1){r_x2[W]}}, r_x2};
  assign w_y  = w_xe * w_xe;

  assign w_p     = $signed({1'b0, r_y3}) - $signed({{(W+1){1'b0}}, r_c3});
  assign w_p_ext = {{(AW-RW){w_p[RW-1]}}, w_p};
  assign w_sum   = r_acc + w_p_ext;
  assign w_last  = (r_cnt == CW'(LEN-1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a1        <= '0;
      r_b1        <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_c3        <= '0;
      r_x2        <= '0;
      r_y3        <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_a1 <= a;
      r_b1 <= b;
      r_c1 <= c;
      r_x2 <= w_x;
      r_c2 <= r_c1;
      r_y3 <= w_y;
      r_c3 <= r_c2;
      r_out_valid <= 1'b0;
      if (clr) begin
        // Flush drops everything in flight, including this cycle's sample.
        r_v1  <= 1'b0;
        r_v2  <= 1'b0;
        r_v3  <= 1'b0;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_v1 <= in_valid;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        if (r_v3) begin
          if (!mode) begin
            r_out_valid <= 1'b1;
            r_result    <= w_p_ext;
          end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_result    <= w_sum;
            r_acc       <= '0;
            r_cnt       <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign count     = r_cnt;

endmodule

// File: tb/tb_sqdiff_acc.sv
// tb/tb_sqdiff_acc.sv - directed bench for sqdiff_acc (W=6, LEN=4)
module tb_sqdiff_acc;
  localparam int W   = 6;
  localparam int LEN = 4;
  localparam int CW  = 3;
  localparam int AW  = 15;

  logic          clk = 1'b0;
  logic          rst, clr, mode, in_valid;
  logic [W-1:0]  a, b, c;
  logic          out_valid;
  logic [AW-1:0] result;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  // Sample table: 0..7 main stream, 8..10 extremes; p values hand-computed.
  int sa[11] = '{4, 5, 2,  0,  9, 63,  16, 10, 63,  0,  0};
  int sb[11] = '{8, 8, 7,  2,  9, 63,   2,  9,  0, 63,  0};
  int sc[11] = '{2, 2, 3, 16, 10, 62,  16,  1,  0, 63, 63};
  int sp[11] = '{14, 7, 22, -12, -10, -62, 180, 0, 3969, 3906, -63};

  wire signed [31:0] res_s = 32'($signed(result));

  sqdiff_acc #(.W(W), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .out_valid(out_valid), .result(result), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int idx, input bit cl);
    in_valid = v;
    clr      = cl;
    a = v ? W'(sa[idx]) : '0;
    b = v ? W'(sb[idx]) : '0;
    c = v ? W'(sc[idx]) : '0;
    @(negedge clk);
  endtask

  // seq entries are sample indices, -1 is a bubble; pulses lists expected mode-1 totals.
  task automatic run(input string nm, input int seq[$], input bit m1, input int pulses[$]);
    int n;
    int cnt_m;
    int np;
    n = seq.size();
    cnt_m = 0;
    np = 0;
    for (int i = 0; i < n + 3; i++) begin
      if (i < n && seq[i] >= 0) drive(1'b1, seq[i], 1'b0);
      else                      drive(1'b0, 0, 1'b0);
      if (i >= 3 && seq[i-3] >= 0) begin
        if (!m1) begin
          chk({nm, "_valid"}, int'(out_valid), 1);
          chk({nm, "_result"}, res_s, sp[seq[i-3]]);
        end else if (cnt_m == LEN - 1) begin
          chk({nm, "_pulse"}, int'(out_valid), 1);
          chk({nm, "_total"}, res_s, (np < pulses.size()) ? pulses[np] : 0);
          np++;
          cnt_m = 0;
        end else begin
          chk({nm, "_nopulse"}, int'(out_valid), 0);
          cnt_m++;
        end
      end else begin
        chk({nm, "_bubble"}, int'(out_valid), 0);
      end
      chk({nm, "_count"}, int'(count), cnt_m);
    end
    if (m1) chk({nm, "_npulses"}, np, pulses.size());
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; c = '0;

    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_count", int'(count), 0);
    end
    rst = 1'b1;

    run("m0_stream", '{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0, '{});
    run("m0_ext", '{8, 9, 10}, 1'b0, '{});
    chk("m0_neg_bits", int'(result), 32'h7FC1);

    mode = 1'b1;
    drive(1'b0, 0, 1'b1);
    run("m1_gap", '{0, 1, -1, -1, 2, 3, 4, 5, 6, 7}, 1'b1, '{31, 108});
    run("m1_max", '{8, 8, 8, 8}, 1'b1, '{15876});

    run("m1_part", '{0, 1}, 1'b1, '{});
    drive(1'b0, 0, 1'b1);
    chk("clr_count", int'(count), 0);
    run("m1_after_clr", '{0, 1, 2, 3}, 1'b1, '{31});

    run("m1_part2", '{0, 1}, 1'b1, '{});
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_result", int'(result), 0);
    rst = 1'b1;
    run("m1_after_rst", '{0, 1, 2, 3}, 1'b1, '{31});

    drive(1'b1, 8, 1'b1);
    chk("clr_same_count", int'(count), 0);
    run("m1_clr_same", '{0, 1, 2, 3}, 1'b1, '{31});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
